cc_cond_unit: RTL and testbench
===============================

# cc_cond_unit

Condition-code register and branch/move condition evaluator for the Y86-64 execute stage. It captures the 3-bit flag vector produced by the 64-bit ALU units (add/sub/and/xor) when an OPq instruction retires through execute. It blocks flag updates when a later pipeline stage reports an exception, and evaluates the jXX/cmovXX condition from the stored flags. It is the consumer end of the ALU flag interface: the ALU units produce `{ZF,SF,OF}`, and this block stores and interprets them.

## Interface
- No parameters. Flag width is fixed at 3 and ifun width at 4.
- `clk  in  1`  sole clock; all state changes on the rising edge.
- `rst  in  1`  asynchronous, active-high reset.
- `cc_in  in  3`  ALU flags: bit 2 = ZF, bit 1 = SF, bit 0 = OF (same layout as the ALU `co` output).
- `cc_valid  in  1`  the execute-stage instruction is OPq and `cc_in` is final (set_cc request).
- `cond_req  in  1`  the execute-stage instruction is jXX or cmovXX and needs `cnd`.
- `ifun  in  4`  condition function code of the execute-stage instruction.
- `stall  in  1`  execute stage stalled this cycle; no state change.
- `exc_in  in  1`  memory or writeback stage status is not AOK.
- `cc_out  out  3`  registered flags, same bit layout as `cc_in`.
- `cnd  out  1`  condition result (combinational from `cc_out`, `ifun`, state).
- `cnd_valid  out  1`  `cnd` is meaningful this cycle.
- `bad_ifun  out  1`  `cond_req` with `ifun` > 6.
- `frozen  out  1`  block is in FROZEN state.

## Operation
- States: RUN, FROZEN. Reset state is RUN.
- Priority each cycle in RUN: `exc_in` > `stall` > `cc_valid`.
  - If `exc_in`=1: `cc_out` holds and the next state is FROZEN, regardless of `cc_valid` or `stall`.
  - Else if `stall`=1: everything holds.
  - Else if `cc_valid`=1: `cc_out` <= `cc_in`.
- FROZEN: `cc_out` holds and all inputs are ignored. The block leaves FROZEN only via `rst`.
- Condition decode, with LT = SF^OF:
  - ifun 0 (always): 1
  - 1 (le): LT|ZF
  - 2 (l): LT
  - 3 (e): ZF
  - 4 (ne): !ZF
  - 5 (ge): !LT
  - 6 (g): !LT&!ZF
  - 7..15: `cnd`=0 and `bad_ifun`=1 when `cond_req`=1.
- `cnd` is evaluated from the registered `cc_out`, not from `cc_in`. A conditional instruction therefore sees the flags of the most recent OPq that was not blocked.
- `cnd_valid` = `cond_req` & RUN & !`stall`. In FROZEN, `cnd`=0, `cnd_valid`=0 and `bad_ifun`=0.
- Simultaneous `cc_valid` and `cond_req` is a protocol violation. The required behaviour: `cnd` uses the old flags and the update still occurs.

## Timing
- Reset values: `cc_out`=3'b100 (ZF=1, SF=0, OF=0), `frozen`=0, `cnd`=decode of 3'b100 with the current `ifun`, `cnd_valid`=0 while `rst` is high.
- Flag update latency: 1 cycle. `cc_in` sampled at edge N appears on `cc_out` after edge N.
- `cnd`, `cnd_valid` and `bad_ifun` have 0-cycle latency from `ifun`, `cond_req` and `stall`.
- `frozen` rises on the edge that samples `exc_in`=1.
- Reset asserted mid-operation clears the state immediately (asynchronously), independent of `clk`.
- Back-to-back unblocked `cc_valid` cycles each update; the last one wins.

## Structure
- Shared package holds:
  - ifun constants C_YES, C_LE, C_L, C_E, C_NE, C_GE, C_G
  - flag bit indices ZF_BIT=2, SF_BIT=1, OF_BIT=0
  - CC_RESET=3'b100
  - state encoding
- One combinational sub-module, `cond_eval` (flags and ifun in, cnd and bad_ifun out), so the decode can be reused by the fetch-stage branch predictor checker.
- The top level contains the CC register, the RUN/FROZEN FSM and the output gating.

## Test plan
- Reset release, `cond_req`=1, ifun=3 -> `cc_out`=3'b100, `cnd`=1, `cnd_valid`=1; ifun=4 -> `cnd`=0.
- `cc_valid`=1, `cc_in`=3'b011 -> next cycle `cc_out`=3'b011; then `cond_req` with ifun 2 -> `cnd`=0 (LT=0), ifun 6 -> `cnd`=1.
- `cc_valid`=1 with `stall`=1 and `cc_in`=3'b010 -> `cc_out` unchanged; `cnd_valid`=0 while stalled.
- `cc_valid`=1, `cc_in`=3'b010, `exc_in`=1 in the same cycle -> `cc_out` unchanged, `frozen`=1; later `cc_valid` pulses are ignored and `cnd_valid` stays 0 until `rst`.
- `cond_req`=1, ifun=9 -> `cnd`=0, `bad_ifun`=1; ifun=0 -> `cnd`=1, `bad_ifun`=0.
- Assert `rst` asynchronously between edges while FROZEN with `cc_out`=3'b001 -> immediately `cc_out`=3'b100, `frozen`=0.

Source files
------------

// File: rtl/cc_cond_unit_pkg.sv
// cc_cond_unit_pkg: shared condition codes, flag layout and FSM encoding
package cc_cond_unit_pkg;
    localparam logic [3:0] C_YES = 4'd0;
    localparam logic [3:0] C_LE  = 4'd1;
    localparam logic [3:0] C_L   = 4'd2;
    localparam logic [3:0] C_E   = 4'd3;
    localparam logic [3:0] C_NE  = 4'd4;
    localparam logic [3:0] C_GE  = 4'd5;
    localparam logic [3:0] C_G   = 4'd6;
    localparam int ZF_BIT = 2;
    localparam int SF_BIT = 1;
    localparam int OF_BIT = 0;
    localparam logic [2:0] CC_RESET = 3'b100;
    typedef enum logic {ST_RUN = 1'b0, ST_FROZEN = 1'b1} state_t;
endpackage

// File: rtl/cc_cond_unit_cond_eval.sv
// cond_eval: decodes a jXX/cmovXX function code against a {ZF,SF,OF} flag vector
module cond_eval
    import cc_cond_unit_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [3:0] ifun,
    output logic       cnd,
    output logic       bad_ifun
);
    logic lt;
    logic zf;
    assign lt = flags[SF_BIT] ^ flags[OF_BIT];
    assign zf = flags[ZF_BIT];
    // Condition decode; codes above C_G are undefined and never taken
    always_comb begin
        cnd = (ifun == C_YES) ? 1'b1 :
              (ifun == C_LE)  ? (lt | zf) :
              (ifun == C_L)   ? lt :
              (ifun == C_E)   ? zf :
              (ifun == C_NE)  ? !zf :
              (ifun == C_GE)  ? !lt :
              (ifun == C_G)   ? (!lt & !zf) : 1'b0;
        bad_ifun = ifun > C_G;
    end
endmodule

// File: rtl/cc_cond_unit.sv
// cc_cond_unit: condition-code register with exception freeze and branch/cmov condition output
module cc_cond_unit
    import cc_cond_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cc_in,
    input  logic       cc_valid,
    input  logic       cond_req,
    input  logic [3:0] ifun,
    input  logic       stall,
    input  logic       exc_in,
    output logic [2:0] cc_out,
    output logic       cnd,
    output logic       cnd_valid,
    output logic       bad_ifun,
    output logic       frozen
);
    state_t     state_q, state_d;
    logic [2:0] cc_q, cc_d;
    logic       run;
    logic       eval_cnd;
    logic       eval_bad;

    cond_eval u_cond_eval (
        .flags    (cc_q),
        .ifun     (ifun),
        .cnd      (eval_cnd),
        .bad_ifun (eval_bad)
    );

    // Next state: an exception freezes the flags for good; otherwise stall beats a flag update
    always_comb begin
        state_d = state_q;
        cc_d    = cc_q;
        if (state_q == ST_RUN) begin
            if (exc_in) state_d = ST_FROZEN;
            else if (!stall && cc_valid) cc_d = cc_in;
        end
    end

    // State and flag register, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cc_q    <= CC_RESET;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
        end
    end

    assign run       = state_q == ST_RUN;
    assign cc_out    = cc_q;
    assign frozen    = !run;
    assign cnd       = run & eval_cnd;
    assign cnd_valid = cond_req & run & !stall & !rst;
    assign bad_ifun  = cond_req & run & eval_bad;
endmodule

// File: tb/tb_cc_cond_unit.sv
// tb_cc_cond_unit: directed self-checking bench for cc_cond_unit
module tb_cc_cond_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] cc_in = 3'b000;
    logic       cc_valid = 1'b0;
    logic       cond_req = 1'b0;
    logic [3:0] ifun = 4'd0;
    logic       stall = 1'b0;
    logic       exc_in = 1'b0;
    logic [2:0] cc_out;
    logic       cnd;
    logic       cnd_valid;
    logic       bad_ifun;
    logic       frozen;
    int         n_tests = 0;
    int         n_fail = 0;

    cc_cond_unit dut (
        .clk       (clk),
        .rst       (rst),
        .cc_in     (cc_in),
        .cc_valid  (cc_valid),
        .cond_req  (cond_req),
        .ifun      (ifun),
        .stall     (stall),
        .exc_in    (exc_in),
        .cc_out    (cc_out),
        .cnd       (cnd),
        .cnd_valid (cnd_valid),
        .bad_ifun  (bad_ifun),
        .frozen    (frozen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cond_chk(input string tag, input logic [3:0] f, input logic e_cnd, input logic e_bad);
        ifun = f;
        #1;
        check({tag, "_cnd"}, {7'd0, cnd}, {7'd0, e_cnd});
        check({tag, "_bad"}, {7'd0, bad_ifun}, {7'd0, e_bad});
    endtask

    initial begin
        tick();
        cond_req = 1'b1;
        ifun = 4'd3;
        #1;
        check("rst_cc", {5'd0, cc_out}, 8'h04);
        check("rst_frozen", {7'd0, frozen}, 8'h00);
        check("rst_cnd", {7'd0, cnd}, 8'h01);
        check("rst_cnd_valid", {7'd0, cnd_valid}, 8'h00);
        rst = 1'b0;
        #1;
        check("rel_cc", {5'd0, cc_out}, 8'h04);
        check("rel_cnd_valid", {7'd0, cnd_valid}, 8'h01);
        cond_chk("rel_e", 4'd3, 1'b1, 1'b0);
        cond_chk("rel_ne", 4'd4, 1'b0, 1'b0);
        cond_req = 1'b0;
        cc_in = 3'b011;
        cc_valid = 1'b1;
        tick();
        cc_valid = 1'b0;
        check("upd_cc", {5'd0, cc_out}, 8'h03);
        cond_req = 1'b1;
        cond_chk("f011_l", 4'd2, 1'b0, 1'b0);
        cond_chk("f011_g", 4'd6, 1'b1, 1'b0);
        cond_chk("f011_le", 4'd1, 1'b0, 1'b0);
        cond_chk("f011_ge", 4'd5, 1'b1, 1'b0);
        cond_req = 1'b0;
        cc_valid = 1'b1;
        cc_in = 3'b110;
        tick();
        check("b2b_first", {5'd0, cc_out}, 8'h06);
        cc_in = 3'b001;
        tick();
        check("b2b_last", {5'd0, cc_out}, 8'h01);
        cond_req = 1'b1;
        cond_chk("f001_l", 4'd2, 1'b1, 1'b0);
        cond_chk("f001_le", 4'd1, 1'b1, 1'b0);
        cc_in = 3'b100;
        cond_chk("sim_old_e", 4'd3, 1'b0, 1'b0);
        tick();
        cc_valid = 1'b0;
        check("sim_upd_cc", {5'd0, cc_out}, 8'h04);
        cond_chk("sim_new_e", 4'd3, 1'b1, 1'b0);
        stall = 1'b1;
        cc_valid = 1'b1;
        cc_in = 3'b010;
        #1;
        check("stall_cnd_valid", {7'd0, cnd_valid}, 8'h00);
        tick();
        check("stall_cc", {5'd0, cc_out}, 8'h04);
        stall = 1'b0;
        cc_valid = 1'b0;
        #1;
        check("unstall_cnd_valid", {7'd0, cnd_valid}, 8'h01);
        cond_chk("bad9", 4'd9, 1'b0, 1'b1);
        cond_chk("bad7", 4'd7, 1'b0, 1'b1);
        cond_chk("bad15", 4'd15, 1'b0, 1'b1);
        cond_chk("yes", 4'd0, 1'b1, 1'b0);
        cond_chk("g_ok", 4'd6, 1'b0, 1'b0);
        cond_req = 1'b0;
        #1;
        check("bad_noreq", {7'd0, bad_ifun}, 8'h00);
        cc_valid = 1'b1;
        cc_in = 3'b001;
        tick();
        check("pre_frz_cc", {5'd0, cc_out}, 8'h01);
        cc_in = 3'b010;
        exc_in = 1'b1;
        tick();
        exc_in = 1'b0;
        check("frz_cc", {5'd0, cc_out}, 8'h01);
        check("frz_flag", {7'd0, frozen}, 8'h01);
        cc_in = 3'b110;
        tick();
        tick();
        cc_valid = 1'b0;
        check("frz_hold_cc", {5'd0, cc_out}, 8'h01);
        check("frz_hold_flag", {7'd0, frozen}, 8'h01);
        cond_req = 1'b1;
        ifun = 4'd0;
        #1;
        check("frz_cnd_valid", {7'd0, cnd_valid}, 8'h00);
        check("frz_cnd", {7'd0, cnd}, 8'h00);
        cond_chk("frz_bad", 4'd9, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        check("async_cc", {5'd0, cc_out}, 8'h04);
        check("async_frozen", {7'd0, frozen}, 8'h00);
        check("async_cnd_valid", {7'd0, cnd_valid}, 8'h00);
        tick();
        rst = 1'b0;
        ifun = 4'd3;
        #1;
        check("post_rst_cnd", {7'd0, cnd}, 8'h01);
        check("post_rst_cnd_valid", {7'd0, cnd_valid}, 8'h01);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
